muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have port start, input, 1: request to begin operation; accepted only in IDLE.
REQ-004 SHALL have port op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with accepted start.
REQ-005 SHALL have port src_a, input, 32: multiplicand / dividend (same operand as ALU SrcA); sampled with accepted start.
REQ-006 SHALL have port src_b, input, 32: multiplier / divisor (same operand as ALU SrcB); sampled with accepted start.
REQ-007 SHALL have port mthi, input, 1: write wdata into HI.
REQ-008 SHALL have port mtlo, input, 1: write wdata into LO.
REQ-009 SHALL have port wdata, input, 32: data for mthi/mtlo.
REQ-010 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when HI/LO hold a new result.
REQ-012 SHALL have port hi, output, 32: HI register (product upper word / remainder); feeds ALU SrcA mux via mfhi.
REQ-013 SHALL have port lo, output, 32: LO register (product lower word / quotient); feeds ALU SrcA mux via mflo.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-015 SHALL leave IDLE only on start=1; transition IDLE->CALC, latch op, src_a, src_b, load iteration counter to 0.
REQ-016 SHALL perform one radix-2 iteration per cycle in CALC (shift-add for MULT*, restoring shift-subtract for DIV*) on operand magnitudes; counter increments 0..31; CALC->FIXUP after iteration 31.
REQ-017 SHALL in FIXUP apply sign correction (signed ops only) and write HI/LO at the FIXUP edge; FIXUP->DONE.
REQ-018 SHALL in DONE assert done=1 for exactly one cycle, busy=0; DONE->IDLE unconditionally.
REQ-019 SHALL give latency: start sampled at edge E0 -> busy=1 after E0 through E33, HI/LO updated and done=1 after E33, busy=0 after E33.
REQ-020 SHALL compute MULT as the 64-bit two's-complement product and MULTU as the 64-bit unsigned product; HI=bits[63:32], LO=bits[31:0].
REQ-021 SHALL compute DIV with quotient truncated toward zero and remainder carrying the dividend's sign; DIVU unsigned; LO=quotient, HI=remainder.
REQ-022 SHALL on divide by zero (src_b=0, DIV or DIVU) give LO=32'hFFFF_FFFF, HI=src_a; normal latency, no trap.
REQ-023 SHALL on DIV 32'h8000_0000 / 32'hFFFF_FFFF give LO=32'h8000_0000, HI=0.
REQ-024 SHALL ignore start while busy=1 or in DONE; no queueing.
REQ-025 SHALL accept mthi/mtlo only in IDLE or DONE; ignored while busy=1.
REQ-026 SHALL give start priority over mthi/mtlo when asserted in the same IDLE cycle; the write is dropped.
REQ-027 SHALL when mthi and mtlo are both asserted write wdata to both HI and LO.
REQ-028 SHALL keep HI/LO unchanged during CALC; partial results are held in internal registers only.
REQ-029 SHALL ignore src_a/src_b/op changes after the start cycle.

Reset
REQ-030 SHALL on reset=1 at any edge, including mid-CALC, force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0; the in-flight operation is discarded.
REQ-031 SHALL give reset priority over start, mthi, mtlo.

Verification
REQ-032 SHALL cover: MULT src_a=32'hFFFF_FFFE (-2), src_b=3 -> after 33 cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, done pulse of 1 cycle.
REQ-033 SHALL cover: MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-034 SHALL cover: DIV -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 7/0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-035 SHALL cover: DIV 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
REQ-036 SHALL cover: start and mthi re-asserted at cycle 10 of a DIVU 100/7 -> both ignored, result LO=14, HI=2 at E33; then mthi wdata=32'hA5A5_A5A5 in IDLE -> HI=32'hA5A5_A5A5, LO unchanged.
REQ-037 SHALL cover: reset at cycle 15 of MULTU 5x6 -> next cycle busy=0, done=0, HI=LO=0; a new start then completes normally with LO=30.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result bundle between the core and the HI/LO
// multiply/divide unit.
//   start, op, src_a, src_b : operation request (op 00 MULT, 01 MULTU,
//                             10 DIV, 11 DIVU)
//   mthi, mtlo, wdata       : direct writes into HI / LO
//   busy, done              : progress and one-cycle completion pulse
//   hi, lo                  : architectural HI / LO registers
// master drives requests (core / bench), slave is the muldiv_unit.
interface muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              mthi;
   logic              mtlo;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, op, src_a, src_b, mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, mthi, mtlo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative radix-2 multiply/divide unit with HI/LO registers.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (clears FSM, counter, HI, LO)
//   bus   : muldiv_unit_if.slave request/result bundle
// Operation: magnitudes are latched on an accepted start, DATA_W iterations
// run in CALC (shift-add or restoring shift-subtract), FIXUP restores signs
// and writes HI/LO, DONE pulses done for one cycle.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  bus
);

   localparam int              CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   // Absolute value of an operand; unsigned ops pass through unchanged.
   // The most negative value maps onto itself, which is its correct
   // unsigned magnitude.
   function automatic logic [DATA_W-1:0] magnitude(
      input logic signed [DATA_W-1:0] v,
      input logic                     use_sign
   );
      logic signed [DATA_W-1:0] n;
      n = -v;
      return (use_sign && (v < 0)) ? $unsigned(n) : $unsigned(v);
   endfunction

   function automatic logic [DATA_W-1:0] cond_neg(
      input logic [DATA_W-1:0] v,
      input logic              neg
   );
      return neg ? -v : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg_wide(
      input logic [2*DATA_W-1:0] v,
      input logic                neg
   );
      return neg ? -v : v;
   endfunction

   // control state (reset)
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   // operation context and partial results (no reset, only meaningful
   // after an accepted start)
   logic                is_div_q, is_div_d;
   logic                neg_res_q, neg_res_d;   // negate product / quotient
   logic                neg_rem_q, neg_rem_d;   // remainder follows dividend
   logic                divz_q, divz_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;           // product accumulator
   logic [2*DATA_W-1:0] mcand_q, mcand_d;       // multiplicand, shifts left
   logic [DATA_W-1:0]   mplier_q, mplier_d;     // multiplier, shifts right
   logic [DATA_W-1:0]   rem_q, rem_d;           // partial remainder
   logic [DATA_W-1:0]   dq_q, dq_d;             // dividend out / quotient in
   logic [DATA_W-1:0]   dvs_q, dvs_d;           // divisor magnitude

   logic                is_signed_op;
   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     shifted, diff;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;
   logic                mt_window;

   assign is_signed_op = ~bus.op[0];
   assign a_neg        = is_signed_op & bus.src_a[DATA_W-1];
   assign b_neg        = is_signed_op & bus.src_b[DATA_W-1];
   assign mag_a        = magnitude(bus.src_a, is_signed_op);
   assign mag_b        = magnitude(bus.src_b, is_signed_op);

   // Restoring divide step: bring the next dividend bit into the remainder
   // and keep the subtraction only if it did not borrow (bit DATA_W clear).
   assign shifted  = {rem_q, dq_q[DATA_W-1]};
   assign diff     = shifted - {1'b0, dvs_q};

   assign prod_fix = cond_neg_wide(acc_q, neg_res_q);
   assign quo_fix  = cond_neg(dq_q, neg_res_q);
   assign rem_fix  = cond_neg(rem_q, neg_rem_q);

   // Register writes only land while idle and not starting, or in DONE.
   assign mt_window = ((state_q == IDLE) && !bus.start) || (state_q == DONE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      divz_d    = divz_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      dq_d      = dq_q;
      dvs_d     = dvs_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CALC;
               cnt_d     = '0;
               is_div_d  = bus.op[1];
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               divz_d    = (bus.src_b == '0);
               acc_d     = '0;
               mcand_d   = {{DATA_W{1'b0}}, mag_a};
               mplier_d  = mag_b;
               rem_d     = '0;
               dq_d      = mag_a;
               dvs_d     = mag_b;
            end
         end
         CALC: begin
            if (is_div_q) begin
               if (!diff[DATA_W]) begin
                  rem_d = diff[DATA_W-1:0];
                  dq_d  = {dq_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d = shifted[DATA_W-1:0];
                  dq_d  = {dq_q[DATA_W-2:0], 1'b0};
               end
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            if (is_div_q) begin
               // Divide by zero: quotient all ones, remainder is the
               // dividend, which the sign-restored remainder already is.
               lo_d = divz_q ? '1 : quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*DATA_W-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (mt_window) begin
         if (bus.mthi) hi_d = bus.wdata;
         if (bus.mtlo) lo_d = bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
   end

   assign bus.busy = (state_q == CALC) || (state_q == FIXUP);
   assign bus.done = (state_q == DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit with hand-computed
// HI/LO results, latency/busy/done timing and mthi/mtlo/reset interplay.
module tb_muldiv_unit;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   logic [31:0] mhi, mlo;   // expected architectural HI/LO

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one operation from IDLE (called #1 after a rising edge) and
   // follows it to the cycle after DONE. Operands are scrambled after the
   // start cycle, start is re-asserted during DONE, and mthi can be raised
   // together with start; none of these may have any effect.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic mt_with_start);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.mthi  = mt_with_start;
      bus.wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;                 // E0
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.op    = ~op;
      bus.src_a = ~a;
      bus.src_b = ~b;
      chk({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
      chk({tag, " done@E0"}, 32'(bus.done), 32'd0);
      chk({tag, " hi@E0"}, bus.hi, mhi);
      repeat (32) @(posedge clk);
      #1;                                 // E32, in FIXUP
      chk({tag, " busy@E32"}, 32'(bus.busy), 32'd1);
      chk({tag, " lo@E32"}, bus.lo, mlo);
      @(posedge clk); #1;                 // E33, in DONE
      chk({tag, " busy@E33"}, 32'(bus.busy), 32'd0);
      chk({tag, " done@E33"}, 32'(bus.done), 32'd1);
      chk({tag, " hi"}, bus.hi, exp_hi);
      chk({tag, " lo"}, bus.lo, exp_lo);
      mhi = exp_hi;
      mlo = exp_lo;
      bus.start = 1'b1;                   // must be ignored in DONE
      @(posedge clk); #1;                 // E34, back in IDLE
      bus.start = 1'b0;
      chk({tag, " done@E34"}, 32'(bus.done), 32'd0);
      chk({tag, " busy@E34"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      mhi       = '0;
      mlo       = '0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset hi", bus.hi, 32'h0);
      chk("reset lo", bus.lo, 32'h0);
      reset = 1'b0;

      run_op("MULT -2*3",   2'b00, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      run_op("MULT -3*-5",  2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 1'b0);
      run_op("MULTU max^2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("MULTU x256",  2'b01, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0);
      run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("DIV 7/-2",    2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("DIVU 7/0",    2'b11, 32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
      run_op("DIV -7/0",    2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
      run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

      // Register writes in IDLE: both at once, then LO alone.
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      chk("mthi+mtlo hi", bus.hi, 32'h1234_5678);
      chk("mthi+mtlo lo", bus.lo, 32'h1234_5678);
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h0000_BEEF;
      @(posedge clk); #1;
      bus.mtlo  = 1'b0;
      chk("mtlo hi", bus.hi, 32'h1234_5678);
      chk("mtlo lo", bus.lo, 32'h0000_BEEF);
      mhi = 32'h1234_5678;
      mlo = 32'h0000_BEEF;

      // start wins over mthi in the same IDLE cycle
      run_op("MULT 3*4 +mthi", 2'b00, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b1);

      // DIVU 100/7 with start and mthi re-asserted at cycle 10
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.src_a = 32'd100;
      bus.src_b = 32'd7;
      @(posedge clk); #1;                 // E0
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;                                 // E10
      bus.start = 1'b1;
      bus.mthi  = 1'b1;
      bus.wdata = 32'hFFFF_0000;
      bus.op    = 2'b00;
      bus.src_a = 32'd9;
      @(posedge clk); #1;                 // E11
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      chk("DIVU busy@E11", 32'(bus.busy), 32'd1);
      chk("DIVU hi held", bus.hi, mhi);
      repeat (21) @(posedge clk);
      #1;                                 // E32
      chk("DIVU done@E32", 32'(bus.done), 32'd0);
      @(posedge clk); #1;                 // E33
      chk("DIVU done@E33", 32'(bus.done), 32'd1);
      chk("DIVU 100/7 lo", bus.lo, 32'd14);
      chk("DIVU 100/7 hi", bus.hi, 32'd2);
      @(posedge clk); #1;                 // E34
      chk("DIVU busy@E34", 32'(bus.busy), 32'd0);
      chk("DIVU done@E34", 32'(bus.done), 32'd0);
      bus.mthi  = 1'b1;
      bus.wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      bus.mthi  = 1'b0;
      chk("mthi idle hi", bus.hi, 32'hA5A5_A5A5);
      chk("mthi idle lo", bus.lo, 32'd14);

      // Reset in the middle of MULTU 5x6
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.src_a = 32'd5;
      bus.src_b = 32'd6;
      @(posedge clk); #1;                 // E0
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;                                 // E14
      chk("pre-reset busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;                 // E15
      reset = 1'b0;
      chk("mid reset busy", 32'(bus.busy), 32'd0);
      chk("mid reset done", 32'(bus.done), 32'd0);
      chk("mid reset hi", bus.hi, 32'h0);
      chk("mid reset lo", bus.lo, 32'h0);
      mhi = '0;
      mlo = '0;
      run_op("MULTU 5*6", 2'b01, 32'd5, 32'd6, 32'h0000_0000, 32'd30, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
